// File: rtl/rom_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter_if
// Description : Bundle of the fetch and load request/response channels plus
//               the ROM address/data pair served by rom_port_arbiter.
//               master : requester/ROM side (drives requests, resp_ready,
//                        rom_data)
//               slave  : arbiter side (drives req_ready, responses,
//                        rom_address)
// Revision    : 1.0 - initial release
// ============================================================================
interface rom_port_arbiter_if;
  // Fetch requester
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_resp_valid;
  logic        if_resp_ready;
  logic [31:0] if_resp_data;
  logic        if_resp_err;
  // Load requester
  logic        ld_req_valid;
  logic        ld_req_ready;
  logic [31:0] ld_addr;
  logic        ld_resp_valid;
  logic        ld_resp_ready;
  logic [31:0] ld_resp_data;
  logic        ld_resp_err;
  // ROM port
  logic [31:0] rom_address;
  logic [31:0] rom_data;

  modport master (
    output if_req_valid, if_addr, if_resp_ready,
    output ld_req_valid, ld_addr, ld_resp_ready,
    output rom_data,
    input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
    input  rom_address
  );

  modport slave (
    input  if_req_valid, if_addr, if_resp_ready,
    input  ld_req_valid, ld_addr, ld_resp_ready,
    input  rom_data,
    output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
    output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
    output rom_address
  );
endinterface
`default_nettype wire

// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_port_arbiter
// Description : Shares a single-port synchronous-read ROM between instruction
//               fetch (if_*) and data load (ld_*). One read issued per cycle,
//               load has priority, fetch is protected by a streak limit.
//               Addresses >= ROM_BYTES return data 0 with err set.
// Ports       : clk   - system clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - rom_port_arbiter_if.slave: fetch/load request and
//                       response channels, rom_address out, rom_data in
// Revision    : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int unsigned ROM_BYTES     = 1024,
  parameter int unsigned MAX_LD_STREAK = 3
) (
  input wire clk,
  input wire rst_n,
  rom_port_arbiter_if.slave bus
);

  localparam logic [3:0]  c_STREAK_MAX = 4'(MAX_LD_STREAK);
  localparam logic [31:0] c_ROM_LIMIT  = 32'(ROM_BYTES);
  localparam logic        c_ID_IF      = 1'b0;
  localparam logic        c_ID_LD      = 1'b1;

  // Read issued last cycle: owner and range flag travel alongside it
  logic        r_infl_valid;
  logic        r_infl_id;
  logic        r_infl_oor;
  logic [3:0]  r_streak;

  logic        r_if_resp_valid;
  logic [31:0] r_if_resp_data;
  logic        r_if_resp_err;
  logic        r_ld_resp_valid;
  logic [31:0] r_ld_resp_data;
  logic        r_ld_resp_err;

  logic        w_elig_if;
  logic        w_elig_ld;
  logic        w_cand_if;
  logic        w_cand_ld;
  logic        w_grant_if;
  logic        w_grant_ld;
  logic [31:0] w_addr;
  logic        w_land_if;
  logic        w_land_ld;
  logic [31:0] w_land_data;

  // A requester may issue only if its previous read is not still in the ROM
  // and its response slot is free or being emptied this cycle (the
  // resp_ready -> req_ready combinational path is deliberate).
  always_comb begin
    w_elig_if  = !(r_infl_valid && (r_infl_id == c_ID_IF)) &&
                 (!r_if_resp_valid || bus.if_resp_ready);
    w_elig_ld  = !(r_infl_valid && (r_infl_id == c_ID_LD)) &&
                 (!r_ld_resp_valid || bus.ld_resp_ready);
    w_cand_if  = bus.if_req_valid && w_elig_if;
    w_cand_ld  = bus.ld_req_valid && w_elig_ld;
    w_grant_ld = w_cand_ld && (!w_cand_if || (r_streak != c_STREAK_MAX));
    w_grant_if = w_cand_if && !w_grant_ld;
    // Without a grant the fetch address is presented anyway; that read is
    // never marked in flight so its data is dropped.
    w_addr     = w_grant_ld ? bus.ld_addr : bus.if_addr;
    w_land_if  = r_infl_valid && (r_infl_id == c_ID_IF);
    w_land_ld  = r_infl_valid && (r_infl_id == c_ID_LD);
    w_land_data = r_infl_oor ? 32'h0 : bus.rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_infl_valid <= 1'b0;
      r_infl_id    <= c_ID_IF;
      r_infl_oor   <= 1'b0;
      r_streak     <= 4'd0;
    end else begin
      r_infl_valid <= w_grant_if || w_grant_ld;
      r_infl_id    <= w_grant_ld ? c_ID_LD : c_ID_IF;
      r_infl_oor   <= (w_addr >= c_ROM_LIMIT);
      // Count load wins only while fetch was ready to go and lost
      if (!w_cand_if || w_grant_if) begin
        r_streak <= 4'd0;
      end else if (w_grant_ld && (r_streak < c_STREAK_MAX)) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  // Response slots: new data landing takes precedence over a consume at the
  // same edge, otherwise a completed handshake empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_resp_valid <= 1'b0;
      r_if_resp_data  <= 32'h0;
      r_if_resp_err   <= 1'b0;
      r_ld_resp_valid <= 1'b0;
      r_ld_resp_data  <= 32'h0;
      r_ld_resp_err   <= 1'b0;
    end else begin
      if (w_land_if) begin
        r_if_resp_valid <= 1'b1;
        r_if_resp_data  <= w_land_data;
        r_if_resp_err   <= r_infl_oor;
      end else if (r_if_resp_valid && bus.if_resp_ready) begin
        r_if_resp_valid <= 1'b0;
        r_if_resp_data  <= 32'h0;
        r_if_resp_err   <= 1'b0;
      end
      if (w_land_ld) begin
        r_ld_resp_valid <= 1'b1;
        r_ld_resp_data  <= w_land_data;
        r_ld_resp_err   <= r_infl_oor;
      end else if (r_ld_resp_valid && bus.ld_resp_ready) begin
        r_ld_resp_valid <= 1'b0;
        r_ld_resp_data  <= 32'h0;
        r_ld_resp_err   <= 1'b0;
      end
    end
  end

  assign bus.if_req_ready  = w_grant_if;
  assign bus.ld_req_ready  = w_grant_ld;
  assign bus.rom_address   = w_addr;
  assign bus.if_resp_valid = r_if_resp_valid;
  assign bus.if_resp_data  = r_if_resp_data;
  assign bus.if_resp_err   = r_if_resp_err;
  assign bus.ld_resp_valid = r_ld_resp_valid;
  assign bus.ld_resp_data  = r_ld_resp_data;
  assign bus.ld_resp_err   = r_ld_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_port_arbiter
// Description : Bench for rom_port_arbiter. A cycle-level model of the
//               arbitration rules predicts grants and response timing; a
//               scoreboard queue per requester holds expected read results
//               that a negedge monitor pops on each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  localparam int unsigned c_ROM_BYTES = 1024;
  localparam int          c_MAX_LD    = 3;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk;
  logic rst_n;
  rom_port_arbiter_if bus();

  rom_port_arbiter #(
    .ROM_BYTES    (c_ROM_BYTES),
    .MAX_LD_STREAK(c_MAX_LD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word i reads back 0xC0DE0000 | i, one cycle after the address
  always @(posedge clk) bus.rom_data <= 32'hC0DE0000 | {16'h0, bus.rom_address[17:2]};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t expect_of(input logic [31:0] a);
    exp_t r;
    r.e = (a >= 32'(c_ROM_BYTES));
    r.d = r.e ? 32'h0 : (32'hC0DE0000 | {16'h0, a[17:2]});
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = 32'h400 + ($urandom_range(0, 255) << 2);
    else a = ($urandom_range(0, 255) << 2) | $urandom_range(0, 3);
    return a;
  endfunction

  // ---------------------------------------------------------------- monitor
  exp_t q_if[$];
  exp_t q_ld[$];
  logic if_acc, ld_acc;
  logic m_infl_if, m_infl_ld, m_full_if, m_full_ld;
  int   m_streak, d_run;
  logic p_hold_if, p_hold_ld;
  logic [31:0] p_if_d, p_ld_d;
  logic p_if_e, p_ld_e;

  always @(negedge clk) begin
    logic e_if, e_ld, c_if, c_ld, g_if, g_ld;
    exp_t x;
    if (!rst_n) begin
      q_if.delete(); q_ld.delete();
      if_acc = 0; ld_acc = 0;
      m_infl_if = 0; m_infl_ld = 0; m_full_if = 0; m_full_ld = 0;
      m_streak = 0; d_run = 0; p_hold_if = 0; p_hold_ld = 0;
      chk("rst_if_resp_valid", bus.if_resp_valid, 0);
      chk("rst_ld_resp_valid", bus.ld_resp_valid, 0);
      chk("rst_if_resp_data", bus.if_resp_data, 0);
      chk("rst_ld_resp_data", bus.ld_resp_data, 0);
      chk("rst_resp_err", {bus.if_resp_err, bus.ld_resp_err}, 0);
    end else begin
      e_if = !m_infl_if && (!m_full_if || bus.if_resp_ready);
      e_ld = !m_infl_ld && (!m_full_ld || bus.ld_resp_ready);
      c_if = bus.if_req_valid && e_if;
      c_ld = bus.ld_req_valid && e_ld;
      g_ld = c_ld && (!c_if || m_streak < c_MAX_LD);
      g_if = c_if && !g_ld;
      chk("if_req_ready", bus.if_req_ready, g_if);
      chk("ld_req_ready", bus.ld_req_ready, g_ld);
      chk("rom_address", bus.rom_address, g_ld ? bus.ld_addr : bus.if_addr);
      chk("if_resp_valid", bus.if_resp_valid, m_full_if);
      chk("ld_resp_valid", bus.ld_resp_valid, m_full_ld);
      if (p_hold_if) chk("if_resp_hold", {bus.if_resp_data, bus.if_resp_err}, {p_if_d, p_if_e});
      if (p_hold_ld) chk("ld_resp_hold", {bus.ld_resp_data, bus.ld_resp_err}, {p_ld_d, p_ld_e});
      // Observed load run length while fetch is waiting and eligible
      if (c_if) begin
        d_run = bus.ld_req_ready ? d_run + 1 : 0;
        chk("ld_streak_limit", d_run <= c_MAX_LD, 1);
      end else d_run = 0;
      if (g_if) q_if.push_back(expect_of(bus.if_addr));
      if (g_ld) q_ld.push_back(expect_of(bus.ld_addr));
      if (bus.if_resp_valid && bus.if_resp_ready) begin
        if (q_if.size() == 0) chk("if_unexpected_resp", 1, 0);
        else begin
          x = q_if.pop_front();
          chk("if_resp_data", bus.if_resp_data, x.d);
          chk("if_resp_err", bus.if_resp_err, x.e);
        end
      end
      if (bus.ld_resp_valid && bus.ld_resp_ready) begin
        if (q_ld.size() == 0) chk("ld_unexpected_resp", 1, 0);
        else begin
          x = q_ld.pop_front();
          chk("ld_resp_data", bus.ld_resp_data, x.d);
          chk("ld_resp_err", bus.ld_resp_err, x.e);
        end
      end
      p_hold_if = bus.if_resp_valid && !bus.if_resp_ready;
      p_hold_ld = bus.ld_resp_valid && !bus.ld_resp_ready;
      p_if_d = bus.if_resp_data; p_if_e = bus.if_resp_err;
      p_ld_d = bus.ld_resp_data; p_ld_e = bus.ld_resp_err;
      if_acc = bus.if_req_valid && bus.if_req_ready;
      ld_acc = bus.ld_req_valid && bus.ld_req_ready;
      // Advance the model by one edge
      m_streak = (c_if && g_ld) ? m_streak + 1 : 0;
      m_full_if = m_infl_if ? 1'b1 : (m_full_if && !bus.if_resp_ready);
      m_full_ld = m_infl_ld ? 1'b1 : (m_full_ld && !bus.ld_resp_ready);
      m_infl_if = g_if;
      m_infl_ld = g_ld;
    end
  end

  // ---------------------------------------------------------------- driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A pending, not-yet-accepted request keeps its address
  task automatic next_if(input logic v);
    if (!bus.if_req_valid || if_acc) begin
      bus.if_req_valid = v;
      bus.if_addr      = rand_addr();
    end
  endtask

  task automatic next_ld(input logic v);
    if (!bus.ld_req_valid || ld_acc) begin
      bus.ld_req_valid = v;
      bus.ld_addr      = rand_addr();
    end
  endtask

  task automatic ld_single(input logic [31:0] a, input logic [31:0] ed, input logic ee,
                           input logic rdy);
    int k;
    step();
    bus.ld_req_valid = 1; bus.ld_addr = a; bus.ld_resp_ready = rdy; bus.if_req_valid = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ld_req_ready) break;
      step();
    end
    chk("ld_accept_timeout", k < 10, 1);
    step();
    bus.ld_req_valid = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.ld_resp_valid) break;
      step();
    end
    chk("ld_resp_timeout", k < 10, 1);
    chk("ld_single_data", bus.ld_resp_data, ed);
    chk("ld_single_err", bus.ld_resp_err, ee);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_if_acc, k;
    rst_n = 0;
    bus.if_req_valid = 0; bus.if_addr = 0; bus.if_resp_ready = 0;
    bus.ld_req_valid = 0; bus.ld_addr = 0; bus.ld_resp_ready = 0;
    repeat (3) step();
    rst_n = 1;
    step();

    // Fetch only: accepted in cycle 0, response in cycle 2, gone in cycle 3
    bus.if_req_valid = 1; bus.if_addr = 32'h8; bus.if_resp_ready = 1; bus.ld_resp_ready = 1;
    @(negedge clk); chk("t1_accept_c0", bus.if_req_ready, 1);
    step(); bus.if_req_valid = 0;
    @(negedge clk); chk("t1_valid_c1", bus.if_resp_valid, 0);
    step();
    @(negedge clk);
    chk("t1_valid_c2", bus.if_resp_valid, 1);
    chk("t1_data_c2", bus.if_resp_data, 32'hC0DE0002);
    chk("t1_err_c2", bus.if_resp_err, 0);
    step();
    @(negedge clk); chk("t1_valid_c3", bus.if_resp_valid, 0);

    // Both requesters valid every cycle, consumers always ready
    for (int i = 0; i < 60; i++) begin
      step(); next_if(1); next_ld(1);
    end
    step(); bus.if_req_valid = 0; bus.ld_req_valid = 0;
    repeat (4) step();

    // Load backpressure while fetch keeps flowing
    ld_single(32'h10, 32'hC0DE0004, 0, 0);
    n_if_acc = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      next_if(1);
      bus.ld_req_valid = 1; bus.ld_addr = 32'h20;
      @(negedge clk);
      chk("t3_ld_data_held", bus.ld_resp_data, 32'hC0DE0004);
      chk("t3_ld_blocked", bus.ld_req_ready, 0);
      if (bus.if_req_ready) n_if_acc++;
    end
    chk("t3_fetch_progress", n_if_acc > 0, 1);
    step(); bus.ld_resp_ready = 1;
    @(negedge clk); chk("t3_ld_reeligible", bus.ld_req_ready, 1);
    step(); bus.ld_req_valid = 0; bus.if_req_valid = 0;
    repeat (4) step();

    // Out-of-range and last in-range word
    ld_single(32'h400, 32'h0, 1, 1);
    ld_single(32'h3FC, 32'hC0DE00FF, 0, 1);
    repeat (3) step();

    // Randomized traffic and backpressure
    for (int i = 0; i < 400; i++) begin
      step();
      next_if($urandom_range(0, 3) != 0);
      next_ld($urandom_range(0, 3) != 0);
      bus.if_resp_ready = ($urandom_range(0, 3) != 0);
      bus.ld_resp_ready = ($urandom_range(0, 3) != 0);
    end
    step();
    bus.if_req_valid = 0; bus.ld_req_valid = 0; bus.if_resp_ready = 1; bus.ld_resp_ready = 1;
    repeat (6) step();
    chk("drain_if_queue", q_if.size(), 0);
    chk("drain_ld_queue", q_ld.size(), 0);

    // Reset in the cycle after a fetch acceptance, with a load response held
    ld_single(32'h10, 32'hC0DE0004, 0, 0);
    step(); bus.if_req_valid = 1; bus.if_addr = 32'h8; bus.if_resp_ready = 1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.if_req_ready) break;
      step();
    end
    chk("t5_if_accept_timeout", k < 10, 1);
    step();
    rst_n = 0; bus.if_req_valid = 0; bus.ld_req_valid = 0;
    #1;
    chk("t5_async_if_valid", bus.if_resp_valid, 0);
    chk("t5_async_ld_valid", bus.ld_resp_valid, 0);
    chk("t5_async_ld_data", bus.ld_resp_data, 0);
    repeat (2) step();
    rst_n = 1; bus.ld_resp_ready = 1;
    repeat (4) step();
    for (int i = 0; i < 16; i++) begin
      step(); next_if(1); next_ld(1);
    end
    step(); bus.if_req_valid = 0; bus.ld_req_valid = 0;
    repeat (5) step();
    chk("final_if_queue", q_if.size(), 0);
    chk("final_ld_queue", q_ld.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_port_arbiter.md
Name: rom_port_arbiter

Overview:
- Shares the single-port, synchronous-read instruction ROM between two requesters: instruction fetch (if_*) and data load (ld_*), e.g. loads from read-only constant tables.
- Sits between the fetch stage / load unit and the rom instance, and drives the ROM address.
- Each requester gets its own valid/ready request channel and its own valid/ready response channel. The block pipelines one ROM read per cycle.
- Arbitration is load-priority with an anti-starvation limit for fetch. Out-of-range addresses are flagged.

Parameters:
- ROM_BYTES, 1024, byte size of the ROM. Addresses >= ROM_BYTES are out of range.
- MAX_LD_STREAK, 3, maximum consecutive load grants while fetch is waiting and eligible. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request present
- if_req_ready  out  1  fetch request accepted this cycle when valid&&ready
- if_addr  in  32  fetch byte address
- if_resp_valid  out  1  fetch response available
- if_resp_ready  in  1  fetch consumer takes the response
- if_resp_data  out  32  fetch read data
- if_resp_err  out  1  fetch address out of range
- ld_req_valid, ld_req_ready, ld_addr, ld_resp_valid, ld_resp_ready, ld_resp_data, ld_resp_err: identical meaning for the load requester
- rom_address  out  32  address to the ROM; the ROM registers data on the next rising edge
- rom_data  in  32  ROM output, valid the cycle after the address is presented

Behaviour:
- Reset (async, rst_n=0):
  - if_resp_valid=ld_resp_valid=0, resp_data=0, resp_err=0.
  - In-flight slot cleared; streak counter=0.
  - Any in-flight read is discarded and never returned.
- Per-requester eligibility: elig_x = !inflight_x && (!x_resp_valid || x_resp_ready), where inflight_x means the read issued last cycle belongs to x.
  - This is a combinational path from resp_ready to req_ready, and it is intended.
- Grant (combinational, at most one per cycle):
  - Only ld valid&&eligible -> ld granted.
  - Only if valid&&eligible -> if granted.
  - Both valid&&eligible -> ld granted, unless streak==MAX_LD_STREAK, in which case if is granted.
  - x_req_ready = grant_x. A requester that is not granted sees ready=0.
- Streak counter:
  - Increments when ld is granted while if_req_valid && elig_if.
  - Clears when if is granted, or in any cycle where !(if_req_valid && elig_if).
  - Saturates at MAX_LD_STREAK.
- rom_address: the granted requester's address. With no grant it holds if_addr (the read is harmless and ignored).
- Issue cycle N (accepted request):
  - Register inflight_valid=1, inflight_id, and the out-of-range flag (addr >= ROM_BYTES).
- Cycle N+1: rom_data is valid. At the end of N+1, load the owner's response register:
  - data = rom_data, or 0 if out of range;
  - err = the out-of-range flag;
  - resp_valid = 1.
- Latency: x_resp_valid rises in cycle N+2 after acceptance in cycle N. Throughput is one read per cycle when the two requesters alternate.
  - A single requester with resp_ready held high sustains one read every 2 cycles, because inflight_x blocks back-to-back issue.
- Response hold:
  - resp_valid/data/err stay stable until resp_valid && resp_ready.
  - They then clear at that edge, unless new data for the same requester lands at the same edge; in that case the new data is loaded.
- Address bits [1:0] are passed through unchecked; the ROM ignores them.
- Simultaneous resp_ready and a new grant to the same requester is legal per the eligibility rule.
- A requester holding req_valid while not granted must keep its address stable. The arbiter does not latch an address until acceptance.

Test Plan:
Bench ROM model: sync read, word i returns 32'hC0DE0000 | i.
1. Fetch only: if_addr=0x8 accepted in cycle 0, if_resp_ready=1 -> if_resp_valid=1 in cycle 2, data=0xC0DE0002, err=0; valid drops in cycle 3.
2. Both valid every cycle, all resp_ready=1, MAX_LD_STREAK=3:
   - the grant sequence must never contain more than 3 consecutive ld grants while fetch is waiting and eligible;
   - every request returns correct data tagged to the correct requester.
3. Backpressure: ld_resp_ready=0 after the response for ld_addr=0x10 arrives:
   - ld_resp_data stays 0xC0DE0004 and ld_req_ready stays 0 for 5 cycles;
   - fetch traffic proceeds during that time;
   - raising ld_resp_ready consumes the response, and ld is eligible again in the same cycle.
4. Out of range: ld_addr=0x400 -> ld_resp_valid=1, ld_resp_err=1, ld_resp_data=0. Then ld_addr=0x3FC -> err=0, data=0xC0DE00FF.
5. Reset mid-flight: assert rst_n=0 the cycle after a fetch is accepted -> outputs go to 0 immediately. After release, no stale if_resp_valid appears and the streak starts at 0.
